// File: rtl/sk6805_serializer.sv
// SK6805 one-wire NRZ serializer: latches a chain of RGB colours and
// shifts them out GRB, MSB first, LED0 first, followed by a low latch gap.
module sk6805_serializer #(
  parameter int NUM_LEDS     = 2,
  parameter int BIT_CYCLES   = 12,
  parameter int T0H_CYCLES   = 3,
  parameter int T1H_CYCLES   = 6,
  parameter int RESET_CYCLES = 1000,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                    clk_10MHz,
  input  logic                    i_rst,
  input  logic [24*NUM_LEDS-1:0]  i_rgb,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_led
);

  localparam int NB = 24 * NUM_LEDS;
  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int BW = $clog2(24) + 1;
  localparam int LW = $clog2(NUM_LEDS) + 1;
  localparam int GW = $clog2(RESET_CYCLES) + 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(23);
  localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [NB-1:0]   sr;
  logic [NB-1:0]   sr_d;
  logic [NB-1:0]   grb;
  logic [CW-1:0]   cyc;
  logic [CW-1:0]   cyc_d;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_d;
  logic [LW-1:0]   led_idx;
  logic [LW-1:0]   led_idx_d;
  logic [GW-1:0]   gap;
  logic [GW-1:0]   gap_d;
  logic [CW-1:0]   th;
  logic            start;
  logic            load;
  logic            bit_end;
  logic            last_bit;
  logic            gap_end;
  logic            led_nxt;
  logic            done_nxt;
  logic            busy_nxt;

  // Wire order is GRB with LED0 first; put it at the shift register MSB.
  always_comb begin
    grb = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      grb[NB-1-24*n -: 24] = {i_rgb[24*n+8 +: 8],
                              i_rgb[24*n+16 +: 8],
                              i_rgb[24*n +: 8]};
    end
  end

  assign start    = i_start | (AUTO_REFRESH != 0);
  assign bit_end  = (cyc == CYC_LAST);
  assign last_bit = bit_end && (bit_cnt == BIT_LAST)
                    && (led_idx == LED_LAST);
  assign gap_end  = (gap == GAP_LAST);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (last_bit) state_d = GAP;
      end
      GAP: begin
        if (gap_end) state_d = IDLE;
      end
      default: state_d = GAP;
    endcase
  end

  always_comb begin
    sr_d      = sr;
    cyc_d     = cyc;
    bit_d     = bit_cnt;
    led_idx_d = led_idx;
    gap_d     = '0;
    if (load) begin
      sr_d      = grb;
      cyc_d     = '0;
      bit_d     = '0;
      led_idx_d = '0;
    end else if (state == SEND) begin
      if (bit_end) begin
        cyc_d = '0;
        sr_d  = {sr[NB-2:0], 1'b0};
        if (bit_cnt == BIT_LAST) begin
          bit_d     = '0;
          led_idx_d = led_idx + LW'(1);
        end else begin
          bit_d = bit_cnt + BW'(1);
        end
      end else begin
        cyc_d = cyc + CW'(1);
      end
    end else if (state == GAP) begin
      gap_d = gap + GW'(1);
    end
  end

  // Line level is computed from next-cycle state so o_led stays registered.
  always_comb begin
    th       = sr_d[NB-1] ? T1H : T0H;
    led_nxt  = (state_d == SEND) && (cyc_d < th);
    done_nxt = (state == GAP) && gap_end;
    busy_nxt = (state_d != IDLE);
  end

  always_ff @(posedge clk_10MHz) begin
    if (i_rst) begin
      state   <= GAP;
      sr      <= '0;
      cyc     <= '0;
      bit_cnt <= '0;
      led_idx <= '0;
      gap     <= '0;
      o_led   <= 1'b0;
      o_done  <= 1'b0;
      o_busy  <= 1'b1;
    end else begin
      state   <= state_d;
      sr      <= sr_d;
      cyc     <= cyc_d;
      bit_cnt <= bit_d;
      led_idx <= led_idx_d;
      gap     <= gap_d;
      o_led   <= led_nxt;
      o_done  <= done_nxt;
      o_busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sk6805_serializer.sv
// Bench for sk6805_serializer: captures the LED line, decodes the NRZ
// pulses and compares them with colours reordered to wire order.
module tb_sk6805_serializer;

  localparam int NL    = 2;
  localparam int NB    = 24 * NL;
  localparam int BITC  = 12;
  localparam int T0    = 3;
  localparam int T1    = 6;
  localparam int RST   = 1000;
  localparam int FB    = NB * BITC;
  localparam int FRAME = FB + RST;

  logic          clk;
  logic          rst;
  logic [NB-1:0] rgb;
  logic          start;
  logic          busy;
  logic          done;
  logic          led;

  logic          rst_ar;
  logic [NB-1:0] rgb_ar;
  logic          busy_ar;
  logic          done_ar;
  logic          led_ar;

  int checks;
  int failures;

  sk6805_serializer #(
    .NUM_LEDS(NL), .BIT_CYCLES(BITC), .T0H_CYCLES(T0),
    .T1H_CYCLES(T1), .RESET_CYCLES(RST), .AUTO_REFRESH(0)
  ) dut (
    .clk_10MHz(clk), .i_rst(rst), .i_rgb(rgb),
    .i_start(start), .o_busy(busy), .o_done(done),
    .o_led(led)
  );

  sk6805_serializer #(
    .NUM_LEDS(NL), .BIT_CYCLES(BITC), .T0H_CYCLES(T0),
    .T1H_CYCLES(T1), .RESET_CYCLES(RST), .AUTO_REFRESH(1)
  ) dut_ar (
    .clk_10MHz(clk), .i_rst(rst_ar), .i_rgb(rgb_ar),
    .i_start(1'b0), .o_busy(busy_ar), .o_done(done_ar),
    .o_led(led_ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB-1:0] rand_rgb();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NB-1:0];
  endfunction

  // Expected wire stream, first bit at the MSB: per LED G, R, B.
  function automatic logic [NB-1:0] wire_bits(input logic [NB-1:0] c);
    logic [NB-1:0] w;
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    w = '0;
    for (int n = 0; n < NL; n++) begin
      r8 = c[24*n+16 +: 8];
      g8 = c[24*n+8 +: 8];
      b8 = c[24*n +: 8];
      w[NB-1-24*n -: 24] = {g8, r8, b8};
    end
    return w;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge where the first bit should already be high.
  task automatic capture_frame(
    input logic [NB-1:0] exp_rgb,
    input int            chg_bit,
    input logic [NB-1:0] chg_rgb,
    input int            poke_bit,
    input int            poke_gap,
    input string         name
  );
    logic          s [FB];
    logic [NB-1:0] w;
    logic [NB-1:0] dec;
    int bad;
    int busy_bad;
    int gap_bad;
    int hi;
    int th;
    int i;
    w        = wire_bits(exp_rgb);
    dec      = '0;
    bad      = 0;
    busy_bad = 0;
    for (int k = 0; k < FB; k++) begin
      s[k] = led;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      if (k == chg_bit * BITC) rgb = chg_rgb;
      if (k == poke_bit * BITC) start = 1'b1;
      else if (k == poke_bit * BITC + 1) start = 1'b0;
      @(negedge clk);
    end
    for (int b = 0; b < NB; b++) begin
      hi = 0;
      th = w[NB-1-b] ? T1 : T0;
      for (int j = 0; j < BITC; j++) begin
        if (s[b*BITC+j] === 1'b1) hi++;
        if (s[b*BITC+j] !== (j < th)) bad++;
      end
      dec[NB-1-b] = (hi > (T0 + T1) / 2);
    end
    checks++;
    if (dec !== w) begin
      failures++;
      $display("FAIL %s data: got %h want %h", name, dec, w);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s shape: got %0d bad samples want 0",
               name, bad);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s busy_send: got %0d bad want 0",
               name, busy_bad);
    end
    i = 0;
    gap_bad = 0;
    while (done !== 1'b1 && i < RST + 20) begin
      if (led !== 1'b0 || busy !== 1'b1) gap_bad++;
      if (i == poke_gap) start = 1'b1;
      else if (i == poke_gap + 1) start = 1'b0;
      i++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (FB + i != FRAME) begin
      failures++;
      $display("FAIL %s frame_len: got %0d want %0d",
               name, FB + i, FRAME);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL %s gap: got %0d bad want 0", name, gap_bad);
    end
    checks++;
    if (busy !== 1'b0 || led !== 1'b0) begin
      failures++;
      $display("FAIL %s done_cycle: got busy=%b led=%b want 0/0",
               name, busy, led);
    end
  endtask

  task automatic test_reset();
    int i;
    int bad;
    rst    = 1'b1;
    rst_ar = 1'b1;
    start  = 1'b0;
    rgb    = '0;
    rgb_ar = rand_rgb();
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    rst_ar = 1'b0;
    checks++;
    if (led !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: got led=%b busy=%b done=%b want 0/1/0",
               led, busy, done);
    end
    i = 0;
    bad = 0;
    while (done !== 1'b1 && i < RST + 20) begin
      if (led !== 1'b0 || busy !== 1'b1) bad++;
      if (i == 500) start = 1'b1;
      else if (i == 501) start = 1'b0;
      i++;
      @(negedge clk);
    end
    checks++;
    if (i != RST) begin
      failures++;
      $display("FAIL reset_gap_len: got %0d want %0d", i, RST);
    end
    checks++;
    if (bad != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_gap: got %0d bad busy=%b want 0 bad busy=0",
               bad, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || led !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got done=%b busy=%b led=%b want 0/0/0",
               done, busy, led);
    end
  endtask

  task automatic test_basic();
    logic [NB-1:0] c;
    c = {24'h000000, 24'hFF0000};
    @(negedge clk);
    rgb = c;
    pulse_start();
    checks++;
    if (led !== 1'b1) begin
      failures++;
      $display("FAIL basic_rise: got %b want 1", led);
    end
    capture_frame(c, -1, '0, -1, -1, "basic");
  endtask

  task automatic test_shadow();
    logic [NB-1:0] c;
    c = {24'h000000, 24'h00FF00};
    @(negedge clk);
    rgb = c;
    pulse_start();
    capture_frame(c, 5, {24'h000000, 24'h0000FF}, -1, -1,
                  "shadow");
  endtask

  task automatic test_start_ignored();
    logic [NB-1:0] c;
    int bad;
    c = rand_rgb();
    @(negedge clk);
    rgb = c;
    pulse_start();
    capture_frame(c, -1, '0, 10, 100, "ignored");
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || led !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL no_extra_frame: got %0d bad want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] c;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      c = rand_rgb();
      rgb = c;
      pulse_start();
      capture_frame(c, -1, '0, -1, -1, $sformatf("b2b%0d", f));
    end
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] c;
    int i;
    int bad;
    c = rand_rgb();
    @(negedge clk);
    rgb = c;
    pulse_start();
    repeat (30 * BITC + 1) @(negedge clk);
    checks++;
    if (led !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got led=%b want 1", led);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (led !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got led=%b done=%b busy=%b want 0/0/1",
               led, done, busy);
    end
    i = 0;
    bad = 0;
    while (done !== 1'b1 && i < RST + 20) begin
      if (led !== 1'b0 || busy !== 1'b1) bad++;
      i++;
      @(negedge clk);
    end
    checks++;
    if (i != RST || bad != 0) begin
      failures++;
      $display("FAIL mid_gap: got len=%0d bad=%0d want %0d/0",
               i, bad, RST);
    end
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || led !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_residual: got %0d bad want 0", bad);
    end
  endtask

  task automatic test_auto_refresh();
    logic          s [FB];
    logic [NB-1:0] c;
    logic [NB-1:0] nxt;
    logic [NB-1:0] w;
    logic [NB-1:0] dec;
    int i;
    int hi;
    int bad;
    c = rand_rgb();
    nxt = rand_rgb();
    @(negedge clk);
    rgb_ar = c;
    rst_ar = 1'b1;
    @(negedge clk);
    rst_ar = 1'b0;
    i = 0;
    while (done_ar !== 1'b1 && i < RST + 20) begin
      i++;
      @(negedge clk);
    end
    checks++;
    if (i != RST) begin
      failures++;
      $display("FAIL ar_reset_gap: got %0d want %0d", i, RST);
    end
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      bad = 0;
      for (int k = 0; k < FB; k++) begin
        s[k] = led_ar;
        if (done_ar !== 1'b0) bad++;
        if (f == 0 && k == 40) rgb_ar = nxt;
        @(negedge clk);
      end
      w = wire_bits(f == 0 ? c : nxt);
      dec = '0;
      for (int b = 0; b < NB; b++) begin
        hi = 0;
        for (int j = 0; j < BITC; j++)
          if (s[b*BITC+j] === 1'b1) hi++;
        dec[NB-1-b] = (hi > (T0 + T1) / 2);
      end
      checks++;
      if (dec !== w) begin
        failures++;
        $display("FAIL ar_data%0d: got %h want %h", f, dec, w);
      end
      i = 0;
      while (done_ar !== 1'b1 && i < RST + 20) begin
        if (led_ar !== 1'b0) bad++;
        i++;
        @(negedge clk);
      end
      checks++;
      if (FB + i != FRAME || bad != 0) begin
        failures++;
        $display("FAIL ar_len%0d: got %0d bad=%0d want %0d bad=0",
                 f, FB + i, bad, FRAME);
      end
      @(negedge clk);
      // Next frame starts in the cycle after the o_done cycle.
      checks++;
      if (led_ar !== 1'b1 || done_ar !== 1'b0) begin
        failures++;
        $display("FAIL ar_restart%0d: got led=%b done=%b want 1/0",
                 f, led_ar, done_ar);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_shadow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_auto_refresh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
